// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle control unit:
//   - state_e      : control FSM state encoding
//   - OP_* / FN_MUL: opcode map and the R-type function code selecting MUL
//   - ALUOP_*      : ALUOp encodings driven towards ALUcontrol
//   - op_is_legal  : true for the five implemented opcodes
//   - is_mul       : true for an R-type instruction whose function is MUL
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        MEM     = 3'd4,
        MULWAIT = 3'd5,
        WB      = 3'd6,
        TRAP    = 3'd7
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;

    localparam logic [3:0] FN_MUL   = 4'b0110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Opcodes 0..4 are implemented; everything above traps.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_BEQ);
    endfunction

    function automatic logic is_mul(input logic [3:0] op, input logic [3:0] fn);
        return (op == OP_RTYPE) && (fn == FN_MUL);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// -----------------------------------------------------------------------------
// mc_wait_counter
// Loadable down-counter with a zero flag. Loading wins over decrementing;
// the counter saturates at zero so an extra decrement request is harmless.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (clears the count)
//   load_i     in   load load_val_i this cycle
//   load_val_i in   value to load (WIDTH bits)
//   dec_i      in   decrement this cycle (ignored while loading)
//   zero_o     out  count is zero
// -----------------------------------------------------------------------------
module mc_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control unit for the 24-bit datapath. Walks each instruction
// through FETCH / DECODE / EXEC / (MEM | MULWAIT) / WB, stalls on a
// multi-cycle multiply and on a wait-state data memory, and traps (sticky)
// on illegal opcodes or a memory access that never completes.
// Parameters:
//   MUL_CYCLES  cycles spent in MULWAIT for MUL (1..15)
//   MEM_TIMEOUT max MEM cycles without MemReady before trapping (1..255)
// Ports:
//   Clock     in   clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   opcode    in   instruction[23:20]
//   Function  in   instruction[3:0]
//   MemReady  in   data memory completes the current access this cycle
//   PCWrite   out  PC loads pc_next
//   IRWrite   out  instruction register loads
//   RegDst    out  1 = rd, 0 = rt
//   Branch    out  branch qualifier (ANDed with zero in the datapath)
//   MemRead   out  data memory read strobe
//   MemWrite  out  data memory write strobe
//   RegWrite  out  register file write enable
//   MemToReg  out  1 = memory data to writeback
//   ALUSrc    out  1 = sign-extended immediate
//   ALUOp     out  00 add, 01 sub, 10 funct
//   Trap      out  illegal opcode or memory timeout, sticky until reset
//   Busy      out  high in every state except FETCH, START and TRAP
// -----------------------------------------------------------------------------
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] opcode,
    input  logic [3:0] Function,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       Trap,
    output logic       Busy
);

    // MULWAIT is entered with MUL_CYCLES-1 loaded and left when the count
    // is zero, so it lasts exactly MUL_CYCLES cycles.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    // Last to_cnt value tolerated before a missing MemReady traps.
    localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

    state_e     state_q;
    logic [3:0] op_q;
    logic [3:0] fn_q;
    logic [7:0] to_cnt_q;

    logic       mul_load;
    logic       mul_dec;
    logic       mul_zero;

    // ------------------------------------------------------------------
    // Multiply wait counter
    // ------------------------------------------------------------------
    assign mul_load = (state_q == EXEC) && is_mul(op_q, fn_q);
    assign mul_dec  = (state_q == MULWAIT);

    mc_wait_counter #(
        .WIDTH (4)
    ) u_mul_cnt (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .load_i     (mul_load),
        .load_val_i (MUL_LOAD),
        .dec_i      (mul_dec),
        .zero_o     (mul_zero)
    );

    // ------------------------------------------------------------------
    // Control FSM: state, latched instruction fields, memory timeout count
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= START;
            op_q     <= '0;
            fn_q     <= '0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                START: begin
                    state_q <= FETCH;
                end

                FETCH: begin
                    state_q <= DECODE;
                end

                DECODE: begin
                    // The only cycle where opcode/Function are sampled;
                    // later changes on those inputs are ignored.
                    op_q    <= opcode;
                    fn_q    <= Function;
                    state_q <= op_is_legal(opcode) ? EXEC : TRAP;
                end

                EXEC: begin
                    case (op_q)
                        OP_RTYPE: state_q <= is_mul(op_q, fn_q) ? MULWAIT : WB;
                        OP_ADDI:  state_q <= WB;
                        OP_LW,
                        OP_SW: begin
                            state_q  <= MEM;
                            to_cnt_q <= '0;
                        end
                        OP_BEQ:   state_q <= FETCH;
                        default:  state_q <= TRAP;
                    endcase
                end

                MEM: begin
                    // A completing access beats the timeout in the same cycle.
                    if (MemReady) begin
                        state_q <= (op_q == OP_SW) ? FETCH : WB;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= TRAP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end

                MULWAIT: begin
                    if (mul_zero) begin
                        state_q <= WB;
                    end
                end

                WB: begin
                    state_q <= FETCH;
                end

                TRAP: begin
                    state_q <= TRAP;
                end

                default: begin
                    state_q <= START;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state and latched instruction.
    // Only the SW completion PCWrite looks at MemReady, and only in MEM.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALUOP_ADD;
        Trap     = 1'b0;

        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
            end

            EXEC: begin
                case (op_q)
                    OP_RTYPE: ALUOp = ALUOP_FUNCT;
                    OP_ADDI,
                    OP_LW,
                    OP_SW:    ALUSrc = 1'b1;
                    OP_BEQ: begin
                        ALUOp   = ALUOP_SUB;
                        Branch  = 1'b1;
                        PCWrite = 1'b1;
                    end
                    default: ;
                endcase
            end

            MEM: begin
                // Address stays formed from the immediate for the whole access.
                ALUSrc   = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
                PCWrite  = (op_q == OP_SW) && MemReady;
            end

            MULWAIT: begin
                ALUOp = ALUOP_FUNCT;
            end

            WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                RegDst   = (op_q == OP_RTYPE);
                MemToReg = (op_q == OP_LW);
                // ADDI keeps the immediate selected so the ALU result being
                // written back stays stable through the writeback cycle.
                ALUSrc   = (op_q == OP_ADDI);
            end

            TRAP: begin
                Trap = 1'b1;
            end

            default: ;
        endcase
    end

    assign Busy = !((state_q == START) || (state_q == FETCH) || (state_q == TRAP));

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Randomized self-checking bench. Each instruction is expanded into a list of
// per-cycle expectations straight from the instruction's phase sequence
// (fetch, decode, execute, memory/multiply wait, writeback), with the
// stimulus for that cycle attached; the list is then played against the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int MUL_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 15;

    // Expected-output word layout:
    // {PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite, RegWrite,
    //  MemToReg, ALUSrc, ALUOp[1:0], Trap, Busy}
    localparam logic [12:0] B_PCW  = 13'h1000;
    localparam logic [12:0] B_IRW  = 13'h0800;
    localparam logic [12:0] B_RDST = 13'h0400;
    localparam logic [12:0] B_BR   = 13'h0200;
    localparam logic [12:0] B_MRD  = 13'h0100;
    localparam logic [12:0] B_MWR  = 13'h0080;
    localparam logic [12:0] B_RW   = 13'h0040;
    localparam logic [12:0] B_M2R  = 13'h0020;
    localparam logic [12:0] B_ASRC = 13'h0010;
    localparam logic [12:0] A_SUB  = 13'h0004;
    localparam logic [12:0] A_FN   = 13'h0008;
    localparam logic [12:0] B_TRAP = 13'h0002;
    localparam logic [12:0] B_BUSY = 13'h0001;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] opcode;
    logic [3:0] Function;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite;
    logic       RegWrite, MemToReg, ALUSrc, Trap, Busy;
    logic [1:0] ALUOp;
    logic [12:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  fn;
        logic        mr;
        logic [12:0] exp;
        string       tag;
        string       note;
    } cyc_t;

    cyc_t q[$];

    multicycle_control #(
        .MUL_CYCLES  (MUL_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .opcode   (opcode),
        .Function (Function),
        .MemReady (MemReady),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .Branch   (Branch),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .ALUSrc   (ALUSrc),
        .ALUOp    (ALUOp),
        .Trap     (Trap),
        .Busy     (Busy)
    );

    assign outs = {PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite,
                   RegWrite, MemToReg, ALUSrc, ALUOp, Trap, Busy};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // mr: -1 = random noise, 0/1 = forced. Instruction fields are only
    // meaningful in the decode cycle; elsewhere they are scrambled.
    task automatic push(input logic [12:0] exp, input bit is_dec, input logic [3:0] op,
                        input logic [3:0] fn, input int mr, input string tag, input string note);
        cyc_t c;
        c.op   = is_dec ? op : 4'($urandom);
        c.fn   = is_dec ? fn : 4'($urandom);
        c.mr   = (mr < 0) ? 1'($urandom) : 1'(mr);
        c.exp  = exp;
        c.tag  = tag;
        c.note = note;
        q.push_back(c);
    endtask

    task automatic add_trap(input int n);
        repeat (n) push(B_TRAP, 0, 4'd0, 4'd0, -1, "trap", "");
    endtask

    // w = MEM cycles with MemReady low before the completing one.
    // timeout = MemReady never arrives (the access is cut off after
    // MEM_TIMEOUT cycles and the caller appends the trap cycles).
    task automatic add_instr(input logic [3:0] op, input logic [3:0] fn, input int w, input bit timeout);
        push(B_IRW, 0, op, fn, -1, "fetch",
             $sformatf("txn op=%0d fn=%0d w=%0d timeout=%0d", op, fn, w, timeout));
        push(B_BUSY, 1, op, fn, -1, "decode", "");
        case (op)
            4'd0: begin
                push(A_FN | B_BUSY, 0, op, fn, -1, "exec_r", "");
                if (fn == 4'b0110)
                    repeat (MUL_CYCLES) push(A_FN | B_BUSY, 0, op, fn, -1, "mulwait", "");
                push(B_PCW | B_RW | B_RDST | B_BUSY, 0, op, fn, -1, "wb_r", "");
            end
            4'd1: begin
                push(B_ASRC | B_BUSY, 0, op, fn, -1, "exec_addi", "");
                push(B_PCW | B_RW | B_ASRC | B_BUSY, 0, op, fn, -1, "wb_addi", "");
            end
            4'd2: begin
                push(B_ASRC | B_BUSY, 0, op, fn, -1, "exec_lw", "");
                repeat (w) push(B_MRD | B_ASRC | B_BUSY, 0, op, fn, 0, "mem_lw_wait", "");
                push(B_MRD | B_ASRC | B_BUSY, 0, op, fn, 1, "mem_lw_done", "");
                push(B_PCW | B_RW | B_M2R | B_BUSY, 0, op, fn, -1, "wb_lw", "");
            end
            4'd3: begin
                push(B_ASRC | B_BUSY, 0, op, fn, -1, "exec_sw", "");
                if (timeout) begin
                    repeat (MEM_TIMEOUT) push(B_MWR | B_ASRC | B_BUSY, 0, op, fn, 0, "mem_sw_stall", "");
                end else begin
                    repeat (w) push(B_MWR | B_ASRC | B_BUSY, 0, op, fn, 0, "mem_sw_wait", "");
                    push(B_MWR | B_ASRC | B_PCW | B_BUSY, 0, op, fn, 1, "mem_sw_done", "");
                end
            end
            4'd4: begin
                push(A_SUB | B_BR | B_PCW | B_BUSY, 0, op, fn, -1, "exec_beq", "");
            end
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1; outputs checked at the negedge.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode   = c.op;
            Function = c.fn;
            MemReady = c.mr;
            if (c.note != "") $display("%s", c.note);
            @(negedge Clock);
            check_eq(c.tag, outs, c.exp);
            @(posedge Clock);
            #1;
        end
    endtask

    // Leaves the DUT in START with one START expectation queued.
    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        check_eq("reset_async", outs, 13'h0);
        @(posedge Clock);
        #1;
        check_eq("reset_hold", outs, 13'h0);
        Reset_n = 1'b1;
        push(13'h0, 0, 4'd0, 4'd0, -1, "start", "");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic [3:0] fn;
        logic [3:0] illegal_ops [3];
        int         w;

        Reset_n  = 1'b0;
        opcode   = 4'd0;
        Function = 4'd0;
        MemReady = 1'b0;
        @(posedge Clock);
        #1;
        do_reset();

        // Directed: one of each, plus the longest non-trapping memory waits.
        add_instr(4'd0, 4'd0, 0, 0);
        add_instr(4'd1, 4'd3, 0, 0);
        add_instr(4'd2, 4'd0, 3, 0);
        add_instr(4'd0, 4'b0110, 0, 0);
        add_instr(4'd4, 4'd0, 0, 0);
        add_instr(4'd3, 4'd0, 0, 0);
        add_instr(4'd2, 4'd0, MEM_TIMEOUT - 1, 0);
        add_instr(4'd3, 4'd9, MEM_TIMEOUT - 1, 0);
        run_queue();

        // Random instruction stream.
        repeat (60) begin
            op = 4'($urandom_range(0, 4));
            fn = ($urandom_range(0, 2) == 0) ? 4'b0110 : 4'($urandom);
            w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_TIMEOUT - 1)
                                              : $urandom_range(0, 2);
            add_instr(op, fn, w, 0);
        end
        run_queue();

        // SW whose memory never answers: timeout trap, sticky.
        add_instr(4'd3, 4'd0, 0, 1);
        add_trap(6);
        run_queue();

        // Illegal opcodes trap right after decode.
        illegal_ops[0] = 4'd9;
        illegal_ops[1] = 4'd5;
        illegal_ops[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            add_instr(illegal_ops[i], 4'($urandom), 0, 0);
            add_trap(4);
            run_queue();
        end

        // Reset in the middle of a stalled SW.
        do_reset();
        add_instr(4'd3, 4'd0, 0, 1);
        repeat (MEM_TIMEOUT - 3) void'(q.pop_back());
        run_queue();
        MemReady = 1'b0;
        #2;
        check_eq("mem_before_reset", outs, B_MWR | B_ASRC | B_BUSY);
        Reset_n = 1'b0;
        #1;
        check_eq("reset_mid_mem", outs, 13'h0);
        @(negedge Clock);
        check_eq("reset_mid_mem_hold", outs, 13'h0);
        MemReady = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("reset_mid_mem_ready", outs, 13'h0);
        Reset_n = 1'b1;
        push(13'h0, 0, 4'd0, 4'd0, 1, "start_after_mem", "");
        add_instr(4'd3, 4'd0, 2, 0);
        add_instr(4'd1, 4'd0, 0, 0);
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
